// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with a DEPTH-entry {PC, instruction} prefetch FIFO.
// Optional macro IF_SQUASH_CNT_EN enables the squashed-entry counter.
module if_prefetch_unit #(
    parameter int unsigned          ADDR_W   = 32,
    parameter int unsigned          INSTR_W  = 32,
    parameter int unsigned          DEPTH    = 4,
    parameter int unsigned          PC_STEP  = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               Branch_taken,
    input  logic [ADDR_W-1:0]  BranchAddr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] Instruction,
    output logic [15:0]        squash_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0]  fetch_pc;
    logic               inflight;
    logic [ADDR_W-1:0]  inflight_addr;
    logic [CW-1:0]      count;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW:0]        occupancy;
    logic               push;
    logic               pop;

    logic [ADDR_W-1:0]  fifo_addr  [DEPTH];
    logic [INSTR_W-1:0] fifo_instr [DEPTH];

    // Occupancy counts the in-flight fetch so its slot is reserved at request time.
    always_comb begin
        occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
        imem_req  = !rst && !freeze && !Branch_taken && (occupancy < (CW+1)'(DEPTH));
        imem_addr = fetch_pc;
        out_valid = (count != '0);
        push      = inflight && !Branch_taken;
        pop       = out_valid && out_ready && !freeze && !Branch_taken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc      <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else if (Branch_taken) begin
            fetch_pc      <= BranchAddr;
            inflight      <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_addr <= fetch_pc;
                fetch_pc      <= fetch_pc + ADDR_W'(PC_STEP);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (Branch_taken) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= inflight_addr;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

    always_comb begin
        PC          = '0;
        Instruction = '0;
        if (out_valid) begin
            PC          = fifo_addr[rd_ptr] + ADDR_W'(PC_STEP);
            Instruction = fifo_instr[rd_ptr];
        end
    end

`ifdef IF_SQUASH_CNT_EN
    logic [15:0] squash_q;
    logic [16:0] squash_sum;

    always_comb squash_sum = {1'b0, squash_q} + 17'(occupancy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            squash_q <= '0;
        end else if (Branch_taken) begin
            squash_q <= squash_sum[16] ? 16'hFFFF : squash_sum[15:0];
        end
    end

    assign squash_count = squash_q;
`else
    assign squash_count = '0;
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit; memory returns {16'hC0DE, addr[15:0]}.
module tb_if_prefetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        Branch_taken;
    logic [31:0] BranchAddr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic [15:0] squash_count;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef IF_SQUASH_CNT_EN
    localparam logic [15:0] SQ_AFTER_B1 = 16'd4;
    localparam logic [15:0] SQ_AFTER_B2 = 16'd6;
    localparam logic [15:0] SQ_AFTER_B3 = 16'd8;
`else
    localparam logic [15:0] SQ_AFTER_B1 = 16'd0;
    localparam logic [15:0] SQ_AFTER_B2 = 16'd0;
    localparam logic [15:0] SQ_AFTER_B3 = 16'd0;
`endif

    if_prefetch_unit #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .DEPTH    (4),
        .PC_STEP  (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .Branch_taken (Branch_taken),
        .BranchAddr   (BranchAddr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .PC           (PC),
        .Instruction  (Instruction),
        .squash_count (squash_count)
    );

    always #5 clk = ~clk;

    // One-cycle-latency instruction memory.
    always @(posedge clk)
        imem_rdata <= imem_req ? {16'hC0DE, imem_addr[15:0]} : 32'hDEAD_BEEF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; Branch_taken = 1'b0; BranchAddr = '0; out_ready = 1'b1;
        #12;
        chk("rst_req",   imem_req, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_pc",    PC, 0);
        chk("rst_instr", Instruction, 0);
        chk("rst_sq",    squash_count, 0);

        // Streaming from reset
        next(); rst = 1'b0; #1;
        chk("s1_req",  imem_req, 1);
        chk("s1_addr", imem_addr, 32'h0);
        next();
        chk("s2_addr",  imem_addr, 32'h4);
        chk("s2_valid", out_valid, 0);
        next();
        chk("s3_valid", out_valid, 1);
        chk("s3_pc",    PC, 32'h4);
        chk("s3_instr", Instruction, 32'hC0DE_0000);
        chk("s3_addr",  imem_addr, 32'h8);
        next();
        chk("s4_pc",    PC, 32'h8);
        chk("s4_instr", Instruction, 32'hC0DE_0004);

        // Asynchronous reset mid-stream
        #2; rst = 1'b1; #1;
        chk("ar_req",   imem_req, 0);
        chk("ar_valid", out_valid, 0);
        chk("ar_pc",    PC, 0);
        chk("ar_instr", Instruction, 0);
        out_ready = 1'b0;
        next(); rst = 1'b0; #1;
        chk("r1_req",  imem_req, 1);
        chk("r1_addr", imem_addr, 32'h0);
        next();
        chk("r2_addr",  imem_addr, 32'h4);
        chk("r2_stale", out_valid, 0);
        next();
        chk("r3_addr", imem_addr, 32'h8);
        next();
        chk("r4_addr", imem_addr, 32'hC);
        next();
        chk("r5_req",   imem_req, 0);
        chk("r5_pc",    PC, 32'h4);
        chk("r5_instr", Instruction, 32'hC0DE_0000);
        next();
        chk("r6_req", imem_req, 0);
        out_ready = 1'b1; #1;
        chk("r6_pc", PC, 32'h4);
        next(); out_ready = 1'b0; #1;
        chk("r7_req",   imem_req, 1);
        chk("r7_addr",  imem_addr, 32'h10);
        chk("r7_pc",    PC, 32'h8);
        chk("r7_instr", Instruction, 32'hC0DE_0004);
        next();
        chk("r8_req", imem_req, 0);

        // Branch with 3 buffered + 1 in flight
        Branch_taken = 1'b1; BranchAddr = 32'h100; #1;
        chk("b1_req", imem_req, 0);
        next(); Branch_taken = 1'b0; out_ready = 1'b1; #1;
        chk("b1_valid", out_valid, 0);
        chk("b1_req2",  imem_req, 1);
        chk("b1_addr",  imem_addr, 32'h100);
        chk("b1_sq",    squash_count, SQ_AFTER_B1);
        next();
        chk("b1_addr2", imem_addr, 32'h104);
        next();
        chk("b1_pc",    PC, 32'h104);
        chk("b1_instr", Instruction, 32'hC0DE_0100);
        chk("b1_addr3", imem_addr, 32'h108);
        next();
        chk("f0_pc", PC, 32'h108);

        // Freeze for three cycles
        freeze = 1'b1; #1;
        chk("f1_req", imem_req, 0);
        chk("f1_pc",  PC, 32'h108);
        next();
        chk("f2_req",   imem_req, 0);
        chk("f2_pc",    PC, 32'h108);
        chk("f2_instr", Instruction, 32'hC0DE_0104);
        next();
        chk("f3_req",   imem_req, 0);
        chk("f3_valid", out_valid, 1);
        chk("f3_pc",    PC, 32'h108);
        next(); freeze = 1'b0; #1;
        chk("f4_req",  imem_req, 1);
        chk("f4_addr", imem_addr, 32'h10C);
        chk("f4_pc",   PC, 32'h108);
        next();
        chk("f5_pc",    PC, 32'h10C);
        chk("f5_instr", Instruction, 32'hC0DE_0108);
        chk("f5_addr",  imem_addr, 32'h110);

        // Branch together with freeze
        Branch_taken = 1'b1; freeze = 1'b1; BranchAddr = 32'h40; #1;
        chk("bf_req", imem_req, 0);
        next(); Branch_taken = 1'b0; #1;
        chk("bf_valid", out_valid, 0);
        chk("bf_req2",  imem_req, 0);
        chk("bf_addr",  imem_addr, 32'h40);
        chk("bf_sq",    squash_count, SQ_AFTER_B2);
        next(); freeze = 1'b0; #1;
        chk("bf_req3",  imem_req, 1);
        chk("bf_addr2", imem_addr, 32'h40);
        next();
        chk("bf_addr3", imem_addr, 32'h44);
        next();
        chk("bf_valid2", out_valid, 1);
        chk("bf_pc",     PC, 32'h44);
        chk("bf_instr",  Instruction, 32'hC0DE_0040);

        // Back-to-back branches: last target wins
        Branch_taken = 1'b1; BranchAddr = 32'h200; #1;
        chk("bb1_req", imem_req, 0);
        next(); BranchAddr = 32'h300; #1;
        chk("bb2_req", imem_req, 0);
        next(); Branch_taken = 1'b0; #1;
        chk("bb_req",  imem_req, 1);
        chk("bb_addr", imem_addr, 32'h300);
        chk("bb_sq",   squash_count, SQ_AFTER_B3);
        next();
        next();
        chk("bb_pc",    PC, 32'h304);
        chk("bb_instr", Instruction, 32'hC0DE_0300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
